playback_controller: RTL and testbench
======================================

Name: playback_controller

Overview:
Sequences the audio stream path between the sample FIFO and the stereo sigma-delta DACs. Holds off playback until the FIFO is prefilled and issues one FIFO read per sample tick. Outputs a registered sample word, muting to midscale when not playing, and detects and counts underruns. Also generates hysteresis-based flow control (clear-to-send) toward the UART sender from the FIFO fill level.

Parameters:
DATA_BITS, 16, FIFO word width ({left[15:8], right[7:0]})
FILL_BITS, 13, width of fifo_fill; FIFO capacity is 2**FILL_BITS
PREFILL, 4096, effective fill (>=) required to leave IDLE
HIGH_MARK, 6144, effective fill (>=) that drops clear_to_send
LOW_MARK, 2048, effective fill (<=) that raises clear_to_send; must be < HIGH_MARK
MUTE_VALUE, 16'h8080, sample_out value while not playing (midscale both channels)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  playback allowed; 0 forces IDLE
tick  input  1  one-cycle sample-rate strobe (clock enable from counter_clock_enable)
fifo_empty  input  1  FIFO empty flag
fifo_full  input  1  FIFO full flag
fifo_fill  input  FILL_BITS  FIFO fill count (wraps to 0 when full)
fifo_rd_data  input  DATA_BITS  FIFO read data, valid 1 cycle after fifo_rd_en
fifo_rd_en  output  1  one-cycle FIFO read strobe
sample_out  output  DATA_BITS  registered sample to DACs
sample_valid  output  1  one-cycle pulse when sample_out updated from FIFO
dac_reset  output  1  high while not playing
playing  output  1  high in PLAY state
clear_to_send  output  1  flow control: 1 = sender may transmit
underrun  output  1  one-cycle pulse on detected underrun
underrun_count  output  8  saturating underrun counter

Behaviour:
- Reset (reset_n=0, async): state=IDLE, fifo_rd_en=0, sample_out=MUTE_VALUE, sample_valid=0, dac_reset=1, playing=0, clear_to_send=1, underrun=0, underrun_count=0, read-pending flag cleared.
- Effective fill: FILL_BITS+1 wide; equals 2**FILL_BITS when fifo_full=1, else zero-extended fifo_fill. All thresholds compare against effective fill.
- States: IDLE and PLAY, with playing=1 and dac_reset=0 only in PLAY.
- IDLE -> PLAY: when enable=1 and effective fill >= PREFILL, evaluated every clk. sample_out stays MUTE_VALUE in IDLE.
- Normal read in PLAY: tick in cycle T with fifo_empty=0 and no read pending:
  - fifo_rd_en=1 in cycle T+1 only; pending flag set.
  - In T+2: sample_out <= fifo_rd_data, sample_valid=1, pending cleared.
  - Latency tick->sample_out is 2 cycles.
- Tick while a read is pending: ignored, no read and no underrun.
- Underrun: tick in PLAY with fifo_empty=1 and no read pending.
  - Next cycle: underrun=1, underrun_count+1 (saturates at 255), state -> IDLE, sample_out <= MUTE_VALUE, no fifo_rd_en.
- enable=0 in PLAY: next cycle state -> IDLE, sample_out <= MUTE_VALUE.
  - A read already issued still completes its data capture cycle, but sample_out is then forced to MUTE_VALUE and sample_valid stays 0.
  - No new reads are issued.
- A tick in the same cycle that enable falls is ignored.
- Flow control, registered and independent of state:
  - effective fill >= HIGH_MARK: clear_to_send <= 0.
  - effective fill <= LOW_MARK: clear_to_send <= 1.
  - Otherwise hold.
- fifo_rd_en is never asserted in IDLE and never while fifo_empty was 1 in the issuing tick cycle.
- Reset asserted mid-read: pending read is discarded, and all outputs return to their reset values immediately.

Test Plan:
- Reset, fill=100, tick every 272 cycles -> playing=0, dac_reset=1, sample_out=16'h8080, no fifo_rd_en, clear_to_send=1.
- Fill ramps to 4096, FIFO model returns 16'h1234 -> PLAY next cycle. First tick gives fifo_rd_en at T+1, sample_out=16'h1234 and sample_valid at T+2.
- Fill ramps 0->6144->3000->2048 -> clear_to_send: 0 at 6144, still 0 at 3000, 1 at 2048.
- fifo_full=1, fifo_fill=0 at reset release with enable=1 -> effective fill 8192, so PLAY entered and clear_to_send drops to 0.
- In PLAY, force fifo_empty=1 at a tick -> underrun pulse, underrun_count=1, IDLE, sample_out=16'h8080. Repeat 300 times -> underrun_count=255.
- Two ticks 1 cycle apart in PLAY -> exactly one fifo_rd_en. Then enable=0 during a pending read -> sample_out=16'h8080, no sample_valid, IDLE.

Source files
------------

// File: rtl/playback_controller.sv
// Playback sequencer between the sample FIFO and the stereo DACs: prefill gating,
// one FIFO read per sample tick, muting, underrun detection and UART flow control.
module playback_controller #(
  parameter int unsigned          DATA_BITS  = 16,
  parameter int unsigned          FILL_BITS  = 13,
  parameter int unsigned          PREFILL    = 4096,
  parameter int unsigned          HIGH_MARK  = 6144,
  parameter int unsigned          LOW_MARK   = 2048,
  parameter logic [DATA_BITS-1:0] MUTE_VALUE = 16'h8080
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 tick,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  input  logic [FILL_BITS-1:0] fifo_fill,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic [DATA_BITS-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 dac_reset,
  output logic                 playing,
  output logic                 clear_to_send,
  output logic                 underrun,
  output logic [7:0]           underrun_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam int unsigned     EFF_W     = FILL_BITS + 1;
  localparam logic [EFF_W-1:0] FULL_FILL = {1'b1, {FILL_BITS{1'b0}}};
  localparam logic [EFF_W-1:0] PREFILL_L = EFF_W'(PREFILL);
  localparam logic [EFF_W-1:0] HIGH_L    = EFF_W'(HIGH_MARK);
  localparam logic [EFF_W-1:0] LOW_L     = EFF_W'(LOW_MARK);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t               state_q, state_d;
  logic                 rd_en_q, rd_en_d;
  logic                 pend_q, pend_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;
  logic [7:0]           ucount_q, ucount_d;
  logic                 cts_q, cts_d;
  logic [EFF_W-1:0]     eff_fill;

  // fifo_fill wraps to zero when the FIFO is full, so restore the true count.
  assign eff_fill = fifo_full ? FULL_FILL : {1'b0, fifo_fill};

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    pend_d     = pend_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    ucount_d   = ucount_q;

    case (state_q)
      ST_IDLE: begin
        sample_d = MUTE_VALUE;
        pend_d   = 1'b0;
        if (enable && (eff_fill >= PREFILL_L)) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!enable) begin
          // An in-flight read still retires here, but its data is discarded.
          state_d  = ST_IDLE;
          sample_d = MUTE_VALUE;
          pend_d   = 1'b0;
        end else if (pend_q) begin
          sample_d = fifo_rd_data;
          valid_d  = 1'b1;
          pend_d   = 1'b0;
        end else if (tick) begin
          if (fifo_empty) begin
            underrun_d = 1'b1;
            ucount_d   = sat_inc8(ucount_q);
            state_d    = ST_IDLE;
            sample_d   = MUTE_VALUE;
          end else begin
            rd_en_d = 1'b1;
            pend_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sample_d = MUTE_VALUE;
        pend_d   = 1'b0;
      end
    endcase
  end

  // Hysteresis between the two marks keeps the sender from toggling on every word.
  always_comb begin
    cts_d = cts_q;
    if (eff_fill >= HIGH_L) begin
      cts_d = 1'b0;
    end else if (eff_fill <= LOW_L) begin
      cts_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      pend_q     <= 1'b0;
      sample_q   <= MUTE_VALUE;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucount_q   <= 8'd0;
      cts_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      pend_q     <= pend_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      ucount_q   <= ucount_d;
      cts_q      <= cts_d;
    end
  end

  assign fifo_rd_en     = rd_en_q;
  assign sample_out     = sample_q;
  assign sample_valid   = valid_q;
  assign playing        = (state_q == ST_PLAY);
  assign dac_reset      = (state_q != ST_PLAY);
  assign clear_to_send  = cts_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller: prefill gating, read timing, underrun,
// flow-control hysteresis, enable and reset behaviour during a pending read.
module tb_playback_controller;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        tick;
  logic        fifo_empty;
  logic        fifo_full;
  logic [12:0] fifo_fill;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        dac_reset;
  logic        playing;
  logic        clear_to_send;
  logic        underrun;
  logic [7:0]  underrun_count;

  int passed = 0;
  int total  = 0;

  playback_controller dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .tick           (tick),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_fill      (fifo_fill),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_en     (fifo_rd_en),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .dac_reset      (dac_reset),
    .playing        (playing),
    .clear_to_send  (clear_to_send),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int rd_seen;
    int play_seen;
    reset_n = 1'b0; enable = 1'b1; tick = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
    fifo_fill = 13'd100; fifo_rd_data = 16'h1234;
    step(); step();
    total++; if (playing !== 1'b0) $display("FAIL rst_playing got %0b want 0", playing); else passed++;
    total++; if (dac_reset !== 1'b1) $display("FAIL rst_dac_reset got %0b want 1", dac_reset); else passed++;
    total++; if (sample_out !== 16'h8080) $display("FAIL rst_sample got %h want 8080", sample_out); else passed++;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en got %0b want 0", fifo_rd_en); else passed++;
    total++; if (sample_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", sample_valid); else passed++;
    total++; if (clear_to_send !== 1'b1) $display("FAIL rst_cts got %0b want 1", clear_to_send); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL rst_underrun got %0b want 0", underrun); else passed++;
    total++; if (underrun_count !== 8'd0) $display("FAIL rst_ucount got %0d want 0", underrun_count); else passed++;
    reset_n = 1'b1;
    rd_seen = 0; play_seen = 0;
    for (int i = 0; i < 600; i++) begin
      tick = (i % 272 == 0);
      step();
      if (fifo_rd_en === 1'b1) rd_seen++;
      if (playing === 1'b1) play_seen++;
    end
    tick = 1'b0;
    total++; if (rd_seen !== 0) $display("FAIL lowfill_rd_en got %0d want 0", rd_seen); else passed++;
    total++; if (play_seen !== 0) $display("FAIL lowfill_playing got %0d want 0", play_seen); else passed++;
    total++; if (sample_out !== 16'h8080) $display("FAIL lowfill_sample got %h want 8080", sample_out); else passed++;
    total++; if (clear_to_send !== 1'b1) $display("FAIL lowfill_cts got %0b want 1", clear_to_send); else passed++;
  endtask

  task automatic test_prefill_play();
    fifo_fill = 13'd2000; step();
    fifo_fill = 13'd4095; step();
    total++; if (playing !== 1'b0) $display("FAIL prefill_4095 got %0b want 0", playing); else passed++;
    fifo_fill = 13'd4096; step();
    total++; if (playing !== 1'b1) $display("FAIL prefill_4096 got %0b want 1", playing); else passed++;
    total++; if (dac_reset !== 1'b0) $display("FAIL play_dac_reset got %0b want 0", dac_reset); else passed++;
    total++; if (sample_out !== 16'h8080) $display("FAIL play_presample got %h want 8080", sample_out); else passed++;
    fifo_rd_data = 16'h1234;
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (fifo_rd_en !== 1'b1) $display("FAIL read_t1_rd_en got %0b want 1", fifo_rd_en); else passed++;
    total++; if (sample_valid !== 1'b0) $display("FAIL read_t1_valid got %0b want 0", sample_valid); else passed++;
    step();
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL read_t2_rd_en got %0b want 0", fifo_rd_en); else passed++;
    total++; if (sample_out !== 16'h1234) $display("FAIL read_t2_sample got %h want 1234", sample_out); else passed++;
    total++; if (sample_valid !== 1'b1) $display("FAIL read_t2_valid got %0b want 1", sample_valid); else passed++;
    step();
    total++; if (sample_valid !== 1'b0) $display("FAIL read_t3_valid got %0b want 0", sample_valid); else passed++;
    total++; if (sample_out !== 16'h1234) $display("FAIL read_t3_sample got %h want 1234", sample_out); else passed++;
  endtask

  task automatic test_flow_control();
    int  fills [8];
    logic exp_cts [8];
    fills = '{0, 6143, 6144, 7000, 3000, 2049, 2048, 100};
    exp_cts = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fifo_fill = 13'(fills[i]);
      step();
      total++;
      if (clear_to_send !== exp_cts[i])
        $display("FAIL cts_fill_%0d got %0b want %0b", fills[i], clear_to_send, exp_cts[i]);
      else passed++;
    end
  endtask

  task automatic test_full_at_reset();
    reset_n = 1'b0; fifo_full = 1'b1; fifo_fill = 13'd0; enable = 1'b1; tick = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    total++; if (playing !== 1'b1) $display("FAIL full_playing got %0b want 1", playing); else passed++;
    total++; if (clear_to_send !== 1'b0) $display("FAIL full_cts got %0b want 0", clear_to_send); else passed++;
    fifo_full = 1'b0; fifo_fill = 13'd4096;
  endtask

  task automatic test_underrun();
    int pulses;
    fifo_rd_data = 16'h1234; fifo_empty = 1'b0;
    tick = 1'b1; step(); tick = 1'b0; step();
    total++; if (sample_out !== 16'h1234) $display("FAIL ur_pre_sample got %h want 1234", sample_out); else passed++;
    fifo_empty = 1'b1;
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (underrun !== 1'b1) $display("FAIL ur_pulse got %0b want 1", underrun); else passed++;
    total++; if (underrun_count !== 8'd1) $display("FAIL ur_count1 got %0d want 1", underrun_count); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL ur_playing got %0b want 0", playing); else passed++;
    total++; if (sample_out !== 16'h8080) $display("FAIL ur_sample got %h want 8080", sample_out); else passed++;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL ur_rd_en got %0b want 0", fifo_rd_en); else passed++;
    step();
    total++; if (underrun !== 1'b0) $display("FAIL ur_pulse_end got %0b want 0", underrun); else passed++;
    total++; if (playing !== 1'b1) $display("FAIL ur_replay got %0b want 1", playing); else passed++;
    pulses = 0;
    for (int i = 0; i < 299; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (underrun === 1'b1) pulses++;
      step();
    end
    total++; if (pulses !== 299) $display("FAIL ur_pulses got %0d want 299", pulses); else passed++;
    total++; if (underrun_count !== 8'd255) $display("FAIL ur_saturate got %0d want 255", underrun_count); else passed++;
    fifo_empty = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rd_cnt;
    int vld_cnt;
    fifo_rd_data = 16'h5A5A;
    rd_cnt = 0; vld_cnt = 0;
    tick = 1'b1; step();
    rd_cnt += int'(fifo_rd_en); vld_cnt += int'(sample_valid);
    step(); tick = 1'b0;
    rd_cnt += int'(fifo_rd_en); vld_cnt += int'(sample_valid);
    for (int i = 0; i < 3; i++) begin
      step();
      rd_cnt += int'(fifo_rd_en); vld_cnt += int'(sample_valid);
    end
    total++; if (rd_cnt !== 1) $display("FAIL b2b_rd_count got %0d want 1", rd_cnt); else passed++;
    total++; if (vld_cnt !== 1) $display("FAIL b2b_valid_count got %0d want 1", vld_cnt); else passed++;
    total++; if (sample_out !== 16'h5A5A) $display("FAIL b2b_sample got %h want 5a5a", sample_out); else passed++;
    fifo_rd_data = 16'hABCD;
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (fifo_rd_en !== 1'b1) $display("FAIL enfall_rd_en got %0b want 1", fifo_rd_en); else passed++;
    enable = 1'b0;
    step();
    total++; if (sample_out !== 16'h8080) $display("FAIL enfall_sample got %h want 8080", sample_out); else passed++;
    total++; if (sample_valid !== 1'b0) $display("FAIL enfall_valid got %0b want 0", sample_valid); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL enfall_playing got %0b want 0", playing); else passed++;
    total++; if (dac_reset !== 1'b1) $display("FAIL enfall_dac_reset got %0b want 1", dac_reset); else passed++;
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      rd_cnt += int'(fifo_rd_en);
    end
    total++; if (rd_cnt !== 0) $display("FAIL enfall_no_read got %0d want 0", rd_cnt); else passed++;
  endtask

  task automatic test_tick_enable_fall();
    enable = 1'b1; step();
    total++; if (playing !== 1'b1) $display("FAIL tef_play got %0b want 1", playing); else passed++;
    tick = 1'b1; enable = 1'b0; step(); tick = 1'b0;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL tef_rd_en got %0b want 0", fifo_rd_en); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL tef_playing got %0b want 0", playing); else passed++;
    step();
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL tef_rd_en_late got %0b want 0", fifo_rd_en); else passed++;
  endtask

  task automatic test_reset_mid_read();
    enable = 1'b1; step();
    fifo_rd_data = 16'h1111;
    tick = 1'b1; step(); tick = 1'b0; step(); step();
    total++; if (sample_out !== 16'h1111) $display("FAIL rmr_pre_sample got %h want 1111", sample_out); else passed++;
    fifo_rd_data = 16'h2222;
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (fifo_rd_en !== 1'b1) $display("FAIL rmr_pending got %0b want 1", fifo_rd_en); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL rmr_rd_en got %0b want 0", fifo_rd_en); else passed++;
    total++; if (sample_out !== 16'h8080) $display("FAIL rmr_sample got %h want 8080", sample_out); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL rmr_playing got %0b want 0", playing); else passed++;
    total++; if (clear_to_send !== 1'b1) $display("FAIL rmr_cts got %0b want 1", clear_to_send); else passed++;
    total++; if (underrun_count !== 8'd0) $display("FAIL rmr_ucount got %0d want 0", underrun_count); else passed++;
    enable = 1'b0;
    step();
    total++; if (sample_valid !== 1'b0) $display("FAIL rmr_valid got %0b want 0", sample_valid); else passed++;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_prefill_play();
    test_flow_control();
    test_full_at_reset();
    test_underrun();
    test_back_to_back();
    test_tick_enable_fall();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
